// File: rtl/json_fb_parser_if.sv
// Byte stream in, committed telemetry frame out.
// Master feeds bytes; slave is the parser.
interface json_fb_parser_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] cmd_t;
    logic [15:0] left_cs;
    logic [15:0] right_cs;
    logic        frame_valid;
    logic        parse_err;

    modport master (
        output rx_valid, rx_data,
        input  cmd_t, left_cs, right_cs, frame_valid, parse_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output cmd_t, left_cs, right_cs, frame_valid, parse_err
    );
endinterface

// File: rtl/json_fb_parser.sv
// Parses {"T":u,"L":n,"R":n}\n feedback frames from the chassis.
// Values commit only on the terminating newline.
module json_fb_parser #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int T_MAX_DIGITS   = 4
) (
    input logic           clk,
    input logic           rst_n,
    json_fb_parser_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] C_LBR = 8'h7B;
    localparam logic [7:0] C_RBR = 8'h7D;
    localparam logic [7:0] C_QT  = 8'h22;
    localparam logic [7:0] C_COL = 8'h3A;
    localparam logic [7:0] C_CMA = 8'h2C;
    localparam logic [7:0] C_MIN = 8'h2D;
    localparam logic [7:0] C_DOT = 8'h2E;
    localparam logic [7:0] C_CR  = 8'h0D;
    localparam logic [7:0] C_NL  = 8'h0A;

    typedef enum logic [3:0] {
        IDLE, KEY_Q1, KEY_CH, KEY_Q2, COLON, VAL_START,
        VAL_SIGN, VAL_INT, VAL_DOT, VAL_FRAC, EOL, RESYNC
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    key_idx_q, key_idx_d;
    logic          neg_q, neg_d;
    logic [15:0]   int_acc_q, int_acc_d;
    logic [3:0]    int_cnt_q, int_cnt_d;
    logic [6:0]    frac_acc_q, frac_acc_d;
    logic [1:0]    frac_cnt_q, frac_cnt_d;
    logic [15:0]   t_tmp_q, t_tmp_d;
    logic [15:0]   l_tmp_q, l_tmp_d;
    logic [15:0]   r_tmp_q, r_tmp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   cmd_t_q, cmd_t_d;
    logic [15:0]   left_q, left_d;
    logic [15:0]   right_q, right_d;
    logic          fv_q, fv_d;
    logic          pe_q, pe_d;

    logic          is_dig, err, store, in_frame;
    logic          sep_ok, close_ok;
    logic [3:0]    dig, int_lim;
    logic [7:0]    key_ch;
    logic [15:0]   int_next, frac_term, mag, sval;

    // Byte classification and value arithmetic
    always_comb begin
        dig       = bus.rx_data[3:0];
        is_dig    = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        int_lim   = (key_idx_q == 2'd0) ? 4'(T_MAX_DIGITS) : 4'd2;
        key_ch    = (key_idx_q == 2'd0) ? 8'h54 :
                    (key_idx_q == 2'd1) ? 8'h4C : 8'h52;
        in_frame  = (state_q != IDLE) && (state_q != RESYNC);
        sep_ok    = (bus.rx_data == C_CMA) && (key_idx_q != 2'd2);
        close_ok  = (bus.rx_data == C_RBR) && (key_idx_q == 2'd2);
        int_next  = int_acc_q * 16'd10 + {12'd0, dig};
        frac_term = (frac_cnt_q == 2'd1) ? {9'd0, frac_acc_q} * 16'd10
                                         : {9'd0, frac_acc_q};
        mag       = int_acc_q * 16'd100 + frac_term;
        sval      = neg_q ? 16'd0 - mag : mag;
    end

    // Next-state, accumulator and output computation
    always_comb begin
        state_d    = state_q;
        key_idx_d  = key_idx_q;
        neg_d      = neg_q;
        int_acc_d  = int_acc_q;
        int_cnt_d  = int_cnt_q;
        frac_acc_d = frac_acc_q;
        frac_cnt_d = frac_cnt_q;
        t_tmp_d    = t_tmp_q;
        l_tmp_d    = l_tmp_q;
        r_tmp_d    = r_tmp_q;
        tmo_d      = tmo_q;
        cmd_t_d    = cmd_t_q;
        left_d     = left_q;
        right_d    = right_q;
        fv_d       = 1'b0;
        pe_d       = 1'b0;
        err        = 1'b0;
        store      = 1'b0;
        if (bus.rx_valid) begin
            tmo_d = '0;
            if (in_frame && bus.rx_data == C_LBR) begin
                pe_d      = 1'b1;
                state_d   = KEY_Q1;
                key_idx_d = 2'd0;
            end else if (in_frame && state_q != EOL && bus.rx_data == C_NL) begin
                pe_d    = 1'b1;
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: if (bus.rx_data == C_LBR) begin
                        state_d   = KEY_Q1;
                        key_idx_d = 2'd0;
                    end
                    KEY_Q1: if (bus.rx_data == C_QT) state_d = KEY_CH;
                            else err = 1'b1;
                    KEY_CH: if (bus.rx_data == key_ch) state_d = KEY_Q2;
                            else err = 1'b1;
                    KEY_Q2: if (bus.rx_data == C_QT) state_d = COLON;
                            else err = 1'b1;
                    COLON: if (bus.rx_data == C_COL) begin
                        state_d    = VAL_START;
                        neg_d      = 1'b0;
                        int_acc_d  = '0;
                        int_cnt_d  = '0;
                        frac_acc_d = '0;
                        frac_cnt_d = '0;
                    end else err = 1'b1;
                    VAL_START, VAL_SIGN: if (is_dig) begin
                        int_acc_d = {12'd0, dig};
                        int_cnt_d = 4'd1;
                        state_d   = VAL_INT;
                    end else if (state_q == VAL_START && bus.rx_data == C_MIN
                                 && key_idx_q != 2'd0) begin
                        neg_d   = 1'b1;
                        state_d = VAL_SIGN;
                    end else err = 1'b1;
                    VAL_INT: if (is_dig) begin
                        if (int_cnt_q < int_lim) begin
                            int_acc_d = int_next;
                            int_cnt_d = int_cnt_q + 4'd1;
                        end else err = 1'b1;
                    end else if (bus.rx_data == C_DOT && key_idx_q != 2'd0) begin
                        state_d = VAL_DOT;
                    end else if (sep_ok || close_ok) begin
                        store = 1'b1;
                    end else err = 1'b1;
                    VAL_DOT: if (is_dig) begin
                        frac_acc_d = {3'd0, dig};
                        frac_cnt_d = 2'd1;
                        state_d    = VAL_FRAC;
                    end else err = 1'b1;
                    VAL_FRAC: if (is_dig) begin
                        if (frac_cnt_q < 2'd2) begin
                            frac_acc_d = frac_acc_q * 7'd10 + {3'd0, dig};
                            frac_cnt_d = frac_cnt_q + 2'd1;
                        end else err = 1'b1;
                    end else if (sep_ok || close_ok) begin
                        store = 1'b1;
                    end else err = 1'b1;
                    EOL: if (bus.rx_data == C_NL) begin
                        cmd_t_d = t_tmp_q;
                        left_d  = l_tmp_q;
                        right_d = r_tmp_q;
                        fv_d    = 1'b1;
                        state_d = IDLE;
                    end else if (bus.rx_data != C_CR) err = 1'b1;
                    RESYNC: if (bus.rx_data == C_NL) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
            if (store) begin
                unique case (key_idx_q)
                    2'd0:    t_tmp_d = int_acc_q;
                    2'd1:    l_tmp_d = sval;
                    default: r_tmp_d = sval;
                endcase
                if (close_ok) begin
                    state_d = EOL;
                end else begin
                    key_idx_d = key_idx_q + 2'd1;
                    state_d   = KEY_Q1;
                end
            end
            if (err) begin
                pe_d    = 1'b1;
                state_d = RESYNC;
            end
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            state_d = IDLE;
            pe_d    = (state_q != RESYNC);
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_idx_q  <= '0;
            neg_q      <= 1'b0;
            int_acc_q  <= '0;
            int_cnt_q  <= '0;
            frac_acc_q <= '0;
            frac_cnt_q <= '0;
            t_tmp_q    <= '0;
            l_tmp_q    <= '0;
            r_tmp_q    <= '0;
            tmo_q      <= '0;
            cmd_t_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            fv_q       <= 1'b0;
            pe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_idx_q  <= key_idx_d;
            neg_q      <= neg_d;
            int_acc_q  <= int_acc_d;
            int_cnt_q  <= int_cnt_d;
            frac_acc_q <= frac_acc_d;
            frac_cnt_q <= frac_cnt_d;
            t_tmp_q    <= t_tmp_d;
            l_tmp_q    <= l_tmp_d;
            r_tmp_q    <= r_tmp_d;
            tmo_q      <= tmo_d;
            cmd_t_q    <= cmd_t_d;
            left_q     <= left_d;
            right_q    <= right_d;
            fv_q       <= fv_d;
            pe_q       <= pe_d;
        end
    end

    assign bus.cmd_t       = cmd_t_q;
    assign bus.left_cs     = left_q;
    assign bus.right_cs    = right_q;
    assign bus.frame_valid = fv_q;
    assign bus.parse_err   = pe_q;
endmodule

// File: tb/tb_json_fb_parser.sv
// Directed bench for json_fb_parser with a frame scoreboard.
// Expected commits are queued as frames are sent.
module tb_json_fb_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    json_fb_parser_if bus ();

    json_fb_parser #(
        .TIMEOUT_CYCLES(50),
        .T_MAX_DIGITS  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int pe_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] t, input logic [15:0] l,
                        input logic [15:0] r);
        exp_t e;
        e.t = t;
        e.l = l;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = s[i];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #1;
    endtask

    // Output monitor: scoreboard pops on each frame_valid pulse
    always @(negedge clk) begin
        if (bus.frame_valid || bus.parse_err)
            check("fv_pe_excl", 32'(bus.frame_valid & bus.parse_err), 0);
        if (bus.parse_err) pe_cnt++;
        if (bus.frame_valid) begin
            exp_t e;
            fv_cnt++;
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_frame: observed %0h expected none",
                       bus.cmd_t);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cmd_t", 32'(bus.cmd_t), 32'(e.t));
                check("left_cs", 32'(bus.left_cs), 32'(e.l));
                check("right_cs", 32'(bus.right_cs), 32'(e.r));
            end
        end
    end

    initial begin
        int fv0, pe0, found;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_t", 32'(bus.cmd_t), 0);
        check("rst_left", 32'(bus.left_cs), 0);
        check("rst_right", 32'(bus.right_cs), 0);
        check("rst_fv", 32'(bus.frame_valid), 0);
        check("rst_pe", 32'(bus.parse_err), 0);

        fv0 = fv_cnt; pe0 = pe_cnt;
        push(16'd1, 16'd5, 16'd5);
        send_str("{\"T\":1,\"L\":0.05,\"R\":0.05}\n", 0);
        check("b2b_fv", fv_cnt - fv0, 1);
        check("b2b_pe", pe_cnt - pe0, 0);

        fv0 = fv_cnt; pe0 = pe_cnt;
        push(16'd1, 16'hFFFE, 16'hFFFE);
        send_str("{\"T\":1,\"L\":-0.02,\"R\":-0.02}\r\n", 3);
        check("gap_fv", fv_cnt - fv0, 1);
        check("gap_pe", pe_cnt - pe0, 0);

        push(16'd1001, 16'd150, 16'd1200);
        send_str("{\"T\":1001,\"L\":1.5,\"R\":12}\n", 0);
        repeat (5) @(negedge clk);
        #1;
        check("hold_cmd_t", 32'(bus.cmd_t), 1001);
        check("hold_right", 32'(bus.right_cs), 1200);
        push(16'd1, 16'd80, 16'd0);
        send_str("{\"T\":1,\"L\":0.8,\"R\":0}\n", 0);

        fv0 = fv_cnt; pe0 = pe_cnt;
        send_str("{\"T\":1,\"", 0);
        check("x_pre_pe", pe_cnt - pe0, 0);
        send_str("X", 0);
        check("x_pe", pe_cnt - pe0, 1);
        send_str("\":0}{\"T\":2,\"L\":0,\"R\":0}\n", 0);
        check("x_fv", fv_cnt - fv0, 0);
        check("x_pe_total", pe_cnt - pe0, 1);
        check("x_hold_t", 32'(bus.cmd_t), 1);
        check("x_hold_l", 32'(bus.left_cs), 80);

        pe0 = pe_cnt;
        send_str("{\"T\":1,\"L\":0.12", 0);
        check("f3_pre_pe", pe_cnt - pe0, 0);
        send_str("3", 0);
        check("f3_pe", pe_cnt - pe0, 1);
        send_str(",\n", 0);
        push(16'd3, 16'(-9999), 16'd9990);
        send_str("{\"T\":3,\"L\":-99.99,\"R\":99.9}\n", 0);
        check("f3_pe_total", pe_cnt - pe0, 1);

        pe0 = pe_cnt;
        send_str("{\"T\":1234", 0);
        check("t4_pe", pe_cnt - pe0, 0);
        send_str("5", 0);
        check("t5_pe", pe_cnt - pe0, 1);
        send_str("\n", 0);
        push(16'd9999, 16'(-100), 16'd725);
        send_str("{\"T\":9999,\"L\":-1,\"R\":7.25}\n", 0);

        pe0 = pe_cnt;
        send_str("{\"T\":-\n", 0);
        check("tneg_pe", pe_cnt - pe0, 1);

        fv0 = fv_cnt; pe0 = pe_cnt;
        send_str("{\"T\":4,\"L\":", 0);
        push(16'd6, 16'd50, 16'(-50));
        send_str("{\"T\":6,\"L\":0.5,\"R\":-0.5}\n", 0);
        check("lbr_pe", pe_cnt - pe0, 1);
        check("lbr_fv", fv_cnt - fv0, 1);

        pe0 = pe_cnt;
        send_str("{\"T\":1,\"L\":1.,", 0);
        check("tdot_pe", pe_cnt - pe0, 1);
        send_str("\n", 0);

        pe0 = pe_cnt;
        send_str("{\"T\":5,", 0);
        found = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.parse_err) begin
                found = c;
                break;
            end
        end
        check("timeout_lat", found, 50);
        @(negedge clk);
        #1;
        check("timeout_pe", pe_cnt - pe0, 1);
        push(16'd8, 16'd0, 16'd100);
        send_str("{\"T\":8,\"L\":0,\"R\":1}\n", 0);
        check("post_to_t", 32'(bus.cmd_t), 8);

        pe0 = pe_cnt;
        send_str("{\"T\":7,\"L\":", 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mrst_cmd_t", 32'(bus.cmd_t), 0);
        check("mrst_right", 32'(bus.right_cs), 0);
        check("mrst_pe", pe_cnt - pe0, 0);
        rst_n = 1'b1;
        push(16'd2, 16'd0, 16'd0);
        send_str("{\"T\":2,\"L\":0,\"R\":0}\n", 0);

        repeat (3) @(negedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/json_fb_parser.md
Name: json_fb_parser

Overview:
- Receive-side counterpart of the drive-command JSON sender.
- Consumes bytes from the UART receiver and parses one-line telemetry/ack frames of the form {"T":<uint>,"L":<num>,"R":<num>}\n, returned by the chassis controller.
- Presents T as unsigned, and L/R as signed hundredths, with a one-cycle frame_valid strobe.
- Flags malformed or stalled frames, then resynchronises on the next newline.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: idle-clock limit inside an open frame before abort.
- T_MAX_DIGITS, 4: maximum decimal digits accepted for the T value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  rx_data holds a received byte this cycle
- rx_data  in  8  received byte
- cmd_t  out  16  last committed T value
- left_cs  out  16  last committed L in hundredths, two's complement
- right_cs  out  16  last committed R in hundredths, two's complement
- frame_valid  out  1  one-cycle pulse: cmd_t/left_cs/right_cs just updated
- parse_err  out  1  one-cycle pulse: frame rejected

Behaviour:
- Reset:
  - Reset is synchronous, active-low: on rising clk with rst_n=0, all outputs become 0 and state becomes IDLE.
  - Accumulators and the timeout counter clear.
  - Reset mid-frame discards the partial frame silently, with no parse_err.
- Interface:
  - No backpressure; every cycle with rx_valid=1 consumes exactly one byte.
  - Cycles with rx_valid=0 change only the timeout counter.
- Accepted grammar (strict order, no whitespace):
  - Sequence is '{' '"' 'T' '"' ':' uint ',' '"' 'L' '"' ':' num ',' '"' 'R' '"' ':' num '}' [ '\r' ] '\n'.
  - uint: 1..T_MAX_DIGITS digits.
  - num: optional '-', then 1..2 integer digits, then optional '.' followed by 1..2 fraction digits.
- States:
  - IDLE: discard all bytes except '{', which goes to KEY_Q1.
  - KEY_Q1: expects '"' -> KEY_CH.
  - KEY_CH: expects the next key in the order T, then L, then R (key_idx 0,1,2) -> KEY_Q2.
  - KEY_Q2: expects '"' -> COLON.
  - COLON: expects ':' -> VAL_START.
  - VAL_START:
    - digit loads int_acc and goes to VAL_INT.
    - '-' is legal only for L/R; it sets neg and goes to VAL_SIGN.
  - VAL_SIGN: a digit is required -> VAL_INT.
  - VAL_INT:
    - digit: int_acc = int_acc*10 + d.
    - '.' (L/R only) -> VAL_DOT.
    - ',' when key_idx<2 -> store value, key_idx++, go to KEY_Q1.
    - '}' when key_idx==2 -> store value, go to EOL.
  - VAL_DOT: a digit is required: frac_acc=d, frac_cnt=1 -> VAL_FRAC.
  - VAL_FRAC:
    - digit when frac_cnt<2 appends.
    - ',' and '}' behave as in VAL_INT.
  - EOL:
    - '\r' is ignored.
    - '\n' commits T/L/R to the outputs and returns to IDLE.
  - RESYNC: discard bytes until '\n' -> IDLE.
- Value conversion:
  - L/R value = int_acc*100 + frac_acc*(frac_cnt==1 ? 10 : 1), negated if neg. Range is ±9999.
  - Stored temporaries hold until commit; outputs change only on a valid '\n'.
- Latency: outputs update and frame_valid=1 on the clock edge that accepts '\n'. Outputs hold between frames.
- Errors (parse_err pulses on the edge that accepts the offending byte; then RESYNC):
  - any unexpected byte;
  - a T digit count above T_MAX_DIGITS;
  - a third integer digit or third fraction digit;
  - '-' on T;
  - empty value, lone '-', trailing '.', or '.' without a leading digit.
- Special bytes and timeout:
  - '{' in any non-IDLE, non-RESYNC state: parse_err pulses, partial data is discarded, state goes to KEY_Q1 (a new frame starts).
  - '\n' in any non-EOL, non-IDLE, non-RESYNC state: parse_err, then IDLE.
  - Timeout counter: clears on each accepted byte and in IDLE.
  - Timeout in a state other than IDLE or RESYNC: when the counter reaches TIMEOUT_CYCLES, parse_err pulses once and state goes to IDLE.
  - Timeout in RESYNC: silently goes to IDLE.
- frame_valid and parse_err are never asserted in the same cycle.

Test Plan:
- Stream `{"T":1,"L":0.05,"R":0.05}\n` with back-to-back rx_valid -> single frame_valid on the '\n' edge; cmd_t=1, left_cs=5, right_cs=5; parse_err never asserted.
- Stream `{"T":1,"L":-0.02,"R":-0.02}\r\n` with 3 idle cycles between bytes -> cmd_t=1, left_cs=16'hFFFE, right_cs=16'hFFFE, one frame_valid.
- Send `{"T":1001,"L":1.5,"R":12}\n`, then `{"T":1,"L":0.8,"R":0}\n` -> first commit gives 1001/150/1200, second gives 1/80/0; outputs hold between frames.
- Send `{"T":1,"X":0}` then `{"T":2,"L":0,"R":0}\n`:
  - parse_err fires on 'X'.
  - The bytes through the following '\n' (in RESYNC) are discarded with no frame_valid.
  - Outputs stay at their prior values.
- Send `{"T":1,"L":0.123,` -> parse_err on '3'; after a trailing '\n', a following valid frame commits normally.
- Send `{"T":5,` then stop -> parse_err exactly TIMEOUT_CYCLES (test value 50) cycles after ','; state returns to IDLE. Separately, assert rst_n=0 mid-frame -> all outputs 0, no parse_err.
